sha256_message_schedule: RTL and testbench

//  Downstream neighbour of message_build in the SHA-2 engine datapath.

---
 rtl/sha256_message_schedule_if.sv | 26 ++
 rtl/sha256_message_schedule.sv | 130 +++++++++++++
 tb/tb_sha256_message_schedule.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_message_schedule_if.sv
// Block-in / word-out bus of the SHA-256 message schedule.
//   data_in[511:0], data_in_last, data_in_valid, data_in_ready : padded block handshake
//   data_out[31:0], data_out_index[5:0], data_out_last,
//   data_out_valid, data_out_ready                             : schedule word handshake
// master: upstream/downstream side (feeds blocks, takes words); slave: the schedule engine.
interface sha256_message_schedule_if;
  logic [511:0] data_in;
  logic         data_in_last;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [31:0]  data_out;
  logic [5:0]   data_out_index;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready;

  modport master (
    output data_in, data_in_last, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_index, data_out_last, data_out_valid
  );

  modport slave (
    input  data_in, data_in_last, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_index, data_out_last, data_out_valid
  );
endinterface

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: takes one padded 512-bit block and streams
// W[0..ROUNDS-1], one 32-bit word per output handshake, with a 16-word
// sliding window. The block-level last flag rides on W[ROUNDS-1].
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : sha256_message_schedule_if.slave (block in, word out)
// Build option:
//   MSG_SCHED_PRELOAD_EN - accept the next block on the same edge that
//   W[ROUNDS-1] leaves, removing the one-cycle idle bubble between blocks.
module sha256_message_schedule #(
  parameter int unsigned ROUNDS = 64
) (
  input logic                      clk,
  input logic                      rst,
  sha256_message_schedule_if.slave bus
);

  localparam int unsigned WIN    = 16;
  localparam int unsigned WORD_W = 32;
  localparam logic [5:0]  T_LAST = 6'(ROUNDS - 1);

  typedef enum logic {IDLE, EXPAND} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] w_q [WIN];
  logic [5:0]        t_q, t_d;
  logic              last_q, last_d;
  logic              valid_q, olast_q, in_ready_q;
  logic              in_ready_c, in_hs_c, out_hs_c, load_c, shift_c;
  logic [WORD_W-1:0] w_new_c;

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Input readiness: registered idle flag, optionally opened on the final word's handshake
`ifdef MSG_SCHED_PRELOAD_EN
  assign in_ready_c = in_ready_q ||
                      ((state_q == EXPAND) && (t_q == T_LAST) && bus.data_out_ready);
`else
  assign in_ready_c = in_ready_q;
`endif

  assign in_hs_c  = bus.data_in_valid && in_ready_c;
  assign out_hs_c = valid_q && bus.data_out_ready;

  // Next window word, modulo 2^32
  assign w_new_c = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    last_d  = last_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_hs_c) begin
          load_c  = 1'b1;
          t_d     = '0;
          last_d  = bus.data_in_last;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (out_hs_c) begin
          shift_c = 1'b1;
          if (t_q == T_LAST) begin
            // in_hs_c can only be high here when the preload path is built in
            if (in_hs_c) begin
              load_c = 1'b1;
              t_d    = '0;
              last_d = bus.data_in_last;
            end else begin
              t_d     = '0;
              state_d = IDLE;
            end
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      t_q        <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      olast_q    <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      last_q     <= last_d;
      valid_q    <= (state_d == EXPAND);
      olast_q    <= (state_d == EXPAND) && last_d && (t_d == T_LAST);
      in_ready_q <= (state_d == IDLE);
    end
  end

  // Sliding window: parallel load of a new block, or shift-in of the next word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) w_q[i] <= '0;
    end else if (load_c) begin
      for (int i = 0; i < WIN; i++) w_q[i] <= bus.data_in[511 - 32*i -: 32];
    end else if (shift_c) begin
      for (int i = 0; i < WIN - 1; i++) w_q[i] <= w_q[i+1];
      w_q[WIN-1] <= w_new_c;
    end
  end

  assign bus.data_in_ready  = in_ready_c;
  assign bus.data_out       = w_q[0];
  assign bus.data_out_index = t_q;
  assign bus.data_out_last  = olast_q;
  assign bus.data_out_valid = valid_q;

endmodule

// File: tb/tb_sha256_message_schedule.sv
module tb_sha256_message_schedule;

  typedef struct {
    logic [511:0] d;
    logic         l;
  } blk_t;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  i;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_message_schedule_if bus();

  sha256_message_schedule #(.ROUNDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  blk_t blk_q[$];
  exp_t exp_q[$];
  int   n_words, n_lasts;
  bit   abc_chk;

`ifdef MSG_SCHED_PRELOAD_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule from the textbook recurrence over the full 64-entry array
  task automatic push_exp(input logic [511:0] d, input logic l);
    logic [31:0] wm [64];
    exp_t e;
    for (int t = 0; t < 16; t++) wm[t] = d[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      wm[t] = (rotr(wm[t-2], 17) ^ rotr(wm[t-2], 19) ^ (wm[t-2] >> 10)) + wm[t-7] +
              (rotr(wm[t-15], 7) ^ rotr(wm[t-15], 18) ^ (wm[t-15] >> 3)) + wm[t-16];
    for (int t = 0; t < 64; t++) begin
      e.w = wm[t];
      e.i = 6'(t);
      e.l = l && (t == 63);
      exp_q.push_back(e);
    end
  endtask

  // Drives queued blocks and downstream ready (mode 0: always, 1: 1,0,0 repeating),
  // scoring every output handshake; optionally stops when stop_idx is presented.
  task automatic run(input int mode, input int stop_idx, input bit gap_chk, output bit stopped);
    int          cyc = 0;
    int          last_hs = -10;
    int          prev_idx = -1;
    bit          prev_stall = 1'b0;
    logic [31:0] pw;
    logic [5:0]  pi;
    logic        pl;
    logic        rdy;
    exp_t        e;
    stopped = 1'b0;
    n_words = 0;
    n_lasts = 0;
    while ((blk_q.size() > 0 || exp_q.size() > 0) && cyc < 2000) begin
      if (blk_q.size() > 0) begin
        bus.data_in_valid = 1'b1;
        bus.data_in       = blk_q[0].d;
        bus.data_in_last  = blk_q[0].l;
      end else begin
        bus.data_in_valid = 1'b0;
      end
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      bus.data_out_ready = rdy;
      #1;
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.data_out_valid), 32'(1));
        chk("stall_word", bus.data_out, pw);
        chk("stall_index", 32'(bus.data_out_index), 32'(pi));
        chk("stall_last", 32'(bus.data_out_last), 32'(pl));
      end
      if (bus.data_out_valid) begin
        if (stop_idx >= 0 && int'(bus.data_out_index) == stop_idx) begin
          bus.data_out_ready = 1'b0;
          bus.data_in_valid  = 1'b0;
          stopped = 1'b1;
          return;
        end
        if (bus.data_out_index != 6'd63)
          chk("in_ready_busy", 32'(bus.data_in_ready), 32'(0));
        if (rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(bus.data_out_index), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("word", bus.data_out, e.w);
            chk("index", 32'(bus.data_out_index), 32'(e.i));
            chk("last", 32'(bus.data_out_last), 32'(e.l));
          end
          if (abc_chk) begin
            case (bus.data_out_index)
              6'd0:  chk("abc_w0", bus.data_out, 32'h6162_6380);
              6'd15: chk("abc_w15", bus.data_out, 32'h0000_0018);
              6'd16: chk("abc_w16", bus.data_out, 32'h6162_6380);
              6'd17: chk("abc_w17", bus.data_out, 32'h000F_0000);
              default: ;
            endcase
          end
          if (gap_chk && prev_idx == 63 && bus.data_out_index == 6'd0)
            chk("block_gap", 32'(cyc - last_hs - 1), 32'(EXP_GAP));
          last_hs  = cyc;
          prev_idx = int'(bus.data_out_index);
          n_words++;
          if (bus.data_out_last) n_lasts++;
        end
        prev_stall = !rdy;
        pw = bus.data_out;
        pi = bus.data_out_index;
        pl = bus.data_out_last;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.data_in_valid && bus.data_in_ready) begin
        push_exp(blk_q[0].d, blk_q[0].l);
        void'(blk_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 1'b1;
    if (cyc >= 2000) chk("run_timeout", 32'(cyc), 32'(0));
  endtask

  // Nothing further may appear once a run has drained
  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_valid", 32'(bus.data_out_valid), 32'(0));
    end
  endtask

  initial begin
    logic [511:0] abc;
    logic [511:0] rnd;
    bit           stopped;
    blk_t         b;

    abc = {32'h6162_6380, 448'd0, 32'h0000_0018};
    for (int i = 0; i < 16; i++) rnd[511 - 32*i -: 32] = $urandom;
    abc_chk = 1'b0;

    bus.data_in        = '0;
    bus.data_in_last   = 1'b0;
    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.data_in_ready), 32'(0));
    chk("rst_valid", 32'(bus.data_out_valid), 32'(0));
    chk("rst_word", bus.data_out, 32'(0));
    chk("rst_index", 32'(bus.data_out_index), 32'(0));
    chk("rst_last", 32'(bus.data_out_last), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.data_in_ready), 32'(1));

    // abc block, last=1
    abc_chk = 1'b1;
    b.d = abc; b.l = 1'b1; blk_q.push_back(b);
    run(0, -1, 1'b0, stopped);
    chk("abc_words", 32'(n_words), 32'(64));
    chk("abc_lasts", 32'(n_lasts), 32'(1));
    idle_check(3);

    // All-zero block, last=0
    abc_chk = 1'b0;
    b.d = '0; b.l = 1'b0; blk_q.push_back(b);
    run(0, -1, 1'b0, stopped);
    chk("zero_words", 32'(n_words), 32'(64));
    chk("zero_lasts", 32'(n_lasts), 32'(0));
    idle_check(2);

    // abc block under 1,0,0 backpressure
    abc_chk = 1'b1;
    b.d = abc; b.l = 1'b1; blk_q.push_back(b);
    run(1, -1, 1'b0, stopped);
    chk("bp_words", 32'(n_words), 32'(64));
    chk("bp_lasts", 32'(n_lasts), 32'(1));
    idle_check(2);
    abc_chk = 1'b0;

    // Back-to-back blocks with valid held high
    b.d = rnd; b.l = 1'b0; blk_q.push_back(b);
    b.d = abc; b.l = 1'b1; blk_q.push_back(b);
    run(0, -1, 1'b1, stopped);
    chk("b2b_words", 32'(n_words), 32'(128));
    chk("b2b_lasts", 32'(n_lasts), 32'(1));
    idle_check(3);

    // Reset in the middle of a block
    b.d = rnd; b.l = 1'b1; blk_q.push_back(b);
    run(0, 20, 1'b0, stopped);
    chk("mid_stop_reached", 32'(stopped), 32'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.data_out_valid), 32'(0));
    chk("mid_rst_in_ready", 32'(bus.data_in_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", 32'(bus.data_out_valid), 32'(0));
    chk("after_rst_in_ready", 32'(bus.data_in_ready), 32'(1));
    chk("after_rst_index", 32'(bus.data_out_index), 32'(0));
    exp_q.delete();
    idle_check(3);
    abc_chk = 1'b1;
    b.d = abc; b.l = 1'b1; blk_q.push_back(b);
    run(0, -1, 1'b0, stopped);
    chk("restart_words", 32'(n_words), 32'(64));
    idle_check(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
